// File: rtl/radix4_multiplier.sv
// radix4_multiplier: parametrised radix-4 Booth sequential multiplier.
// Signed or unsigned per operation; fixed WIDTH/2+1 iteration latency.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   op_start     start request, accepted in IDLE or DONE
//   op_clear     synchronous abort, returns to IDLE
//   op_signed    1 = two's-complement operands, 0 = unsigned
//   multiplier   operand B, latched with op_start
//   multiplicand operand A, latched with op_start
//   op_busy      high while calculating
//   op_done      high while the result is valid
//   result       registered 2*WIDTH-bit product
module radix4_multiplier #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 op_start,
    input  logic                 op_clear,
    input  logic                 op_signed,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 op_busy,
    output logic                 op_done,
    output logic [2*WIDTH-1:0]   result
);

    // Operands widen by two bits so the digit count is even and the
    // same in both modes; the upper field has headroom for +/-2A.
    localparam int EW = WIDTH + 2;
    localparam int UW = WIDTH + 4;
    localparam int AW = UW + EW + 1;
    localparam int N  = WIDTH / 2 + 1;
    localparam int CW = $clog2(N + 1);

    localparam logic [CW-1:0] N_C   = CW'(N);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [EW-1:0]   a_q;
    logic [AW-1:0]   acc_q;
    logic [AW-1:0]   acc_nxt;
    logic [CW-1:0]   cnt_q;
    logic [EW-1:0]   a_ext;
    logic [EW-1:0]   b_ext;
    logic [UW-1:0]   a_w;
    logic [UW-1:0]   addend;
    logic [UW-1:0]   upper_sum;
    logic            accept;
    logic            last;

    assign a_ext = {{2{op_signed & multiplicand[WIDTH-1]}}, multiplicand};
    assign b_ext = {{2{op_signed & multiplier[WIDTH-1]}}, multiplier};

    assign accept = op_start && (state == IDLE || state == DONE);
    assign last   = (state == CALC) && (cnt_q == ONE_C);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clear beats start
    always_comb begin
        state_nxt = state;
        if (op_clear) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: if (op_start) state_nxt = CALC;
                CALC: if (last)     state_nxt = DONE;
                DONE: if (op_start) state_nxt = CALC;
                default:            state_nxt = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        op_busy = (state == CALC);
        op_done = (state == DONE);
    end

    // Booth recoding of the low three accumulator bits
    always_comb begin
        a_w = {{2{a_q[EW-1]}}, a_q};
        case (acc_q[2:0])
            3'b001, 3'b010: addend = a_w;
            3'b011:         addend = a_w << 1;
            3'b100:         addend = -(a_w << 1);
            3'b101, 3'b110: addend = -a_w;
            default:        addend = '0;
        endcase
        upper_sum = acc_q[AW-1 -: UW] + addend;
        acc_nxt   = $signed({upper_sum, acc_q[EW:0]}) >>> 2;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset || op_clear) begin
            a_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            result <= '0;
        end else if (accept) begin
            a_q    <= a_ext;
            acc_q  <= {{UW{1'b0}}, b_ext, 1'b0};
            cnt_q  <= N_C;
            result <= '0;
        end else if (state == CALC) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q - ONE_C;
            // Product sits just above the guard bit after the last shift
            if (last) begin
                result <= acc_nxt[2*WIDTH:1];
            end
        end
    end

endmodule

// File: tb/tb_radix4_multiplier.sv
// tb_radix4_multiplier: directed and table-driven checks of the
// Booth multiplier at WIDTH=64 and WIDTH=8 with a result scoreboard.
module tb_radix4_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          st64, clr64, sg64;
    logic [63:0]   mr64, md64;
    logic          busy64, done64;
    logic [127:0]  res64;
    logic          st8, clr8, sg8;
    logic [7:0]    mr8, md8;
    logic          busy8, done8;
    logic [15:0]   res8;

    int checks = 0;
    int errors = 0;

    logic [127:0] sb64[$];
    logic [15:0]  sb8[$];
    logic [127:0] last64;

    radix4_multiplier #(.WIDTH(64)) d64 (
        .clk          (clk),
        .reset        (reset),
        .op_start     (st64),
        .op_clear     (clr64),
        .op_signed    (sg64),
        .multiplier   (mr64),
        .multiplicand (md64),
        .op_busy      (busy64),
        .op_done      (done64),
        .result       (res64)
    );

    radix4_multiplier #(.WIDTH(8)) d8 (
        .clk          (clk),
        .reset        (reset),
        .op_start     (st8),
        .op_clear     (clr8),
        .op_signed    (sg8),
        .multiplier   (mr8),
        .multiplicand (md8),
        .op_busy      (busy8),
        .op_done      (done8),
        .result       (res8)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] model64(input logic s,
            input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea, eb;
        ea = {{64{s & a[63]}}, a};
        eb = {{64{s & b[63]}}, b};
        return ea * eb;
    endfunction

    function automatic logic [15:0] model8(input logic s,
            input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ea, eb;
        ea = {{8{s & a[7]}}, a};
        eb = {{8{s & b[7]}}, b};
        return ea * eb;
    endfunction

    // Start at the current cycle, expect done exactly 33 edges later
    task automatic run64(input logic s, input logic [63:0] a,
                         input logic [63:0] b, input logic [127:0] exp,
                         input bit pulse);
        sg64 = s;
        md64 = a;
        mr64 = b;
        st64 = 1'b1;
        sb64.push_back(exp);
        tick();
        st64 = 1'b0;
        md64 = {$urandom, $urandom};
        mr64 = {$urandom, $urandom};
        sg64 = ~s;
        chk("start64_busy", 128'(busy64), 128'd1);
        chk("start64_done", 128'(done64), 128'd0);
        chk("start64_res", res64, 128'd0);
        for (int k = 1; k <= 33; k++) begin
            st64 = (pulse && k == 5);
            tick();
            chk("calc64_flags", 128'({busy64, done64}),
                (k < 33) ? 128'd2 : 128'd1);
        end
        st64 = 1'b0;
        last64 = sb64.pop_front();
        chk("product64", res64, last64);
    endtask

    task automatic run8(input logic s, input logic [7:0] a,
                        input logic [7:0] b);
        sg8 = s;
        md8 = a;
        mr8 = b;
        st8 = 1'b1;
        sb8.push_back(model8(s, a, b));
        tick();
        st8 = 1'b0;
        md8 = 8'($urandom);
        mr8 = 8'($urandom);
        chk("start8_flags", 128'({busy8, done8, res8}), 128'h20000);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("calc8_flags", 128'({busy8, done8}),
                (k < 5) ? 128'd2 : 128'd1);
        end
        chk("product8", 128'(res8), 128'(sb8.pop_front()));
    endtask

    logic [7:0] vals [16];

    initial begin
        vals = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7F, 8'h80, 8'h81, 8'hFF,
                 8'hFE, 8'h55, 8'hAA, 8'h40, 8'h3F, 8'hC0, 8'h19, 8'hE7};
        reset = 1'b1;
        st64 = 0; clr64 = 0; sg64 = 0; mr64 = '0; md64 = '0;
        st8 = 0; clr8 = 0; sg8 = 0; mr8 = '0; md8 = '0;
        tick();
        tick();
        chk("reset64", 128'({busy64, done64}), 128'd0);
        chk("reset64_res", res64, 128'd0);
        chk("reset8", 128'({busy8, done8, res8}), 128'd0);
        reset = 1'b0;
        tick();

        run64(1'b1, '1, '1, 128'd1, 1'b0);
        repeat (3) tick();
        chk("hold64_done", 128'(done64), 128'd1);
        chk("hold64_res", res64, last64);

        run64(1'b0, '1, '1, 128'hFFFFFFFFFFFFFFFE0000000000000001, 1'b0);
        run64(1'b1, 64'h8000000000000000, 64'h8000000000000000,
              128'h40000000000000000000000000000000, 1'b0);
        run64(1'b1, 64'hFFFFFFFFFFFFFFFD, 64'd5, ~128'd14, 1'b1);
        run64(1'b0, 64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,
              128'h7FFFFFFFFFFFFFFF8000000000000000, 1'b0);

        sg64 = 1'b1; md64 = 64'd7; mr64 = 64'd9; st64 = 1'b1;
        tick();
        st64 = 1'b0;
        repeat (9) tick();
        clr64 = 1'b1;
        tick();
        clr64 = 1'b0;
        chk("clear64", 128'({busy64, done64}), 128'd0);
        chk("clear64_res", res64, 128'd0);

        clr64 = 1'b1; st64 = 1'b1;
        tick();
        clr64 = 1'b0; st64 = 1'b0;
        chk("clear_start64", 128'({busy64, done64}), 128'd0);

        run64(1'b1, 64'd7, 64'd9, 128'd63, 1'b0);
        for (int i = 0; i < 6; i++) begin
            logic [63:0] a, b;
            logic s;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            s = i[0];
            run64(s, a, b, model64(s, a, b), (i == 2));
        end

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 16; i++)
                for (int j = 0; j < 16; j++)
                    run8(s[0], vals[i], vals[j]);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
